pipeline_mem_arbiter: RTL

PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

---
 rtl/pipeline_mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
// Two-port (instruction fetch / data) arbiter in front of one shared memory.
// Only one memory transaction is outstanding at a time. The data port wins
// by default. After MAX_D_STREAK back-to-back data grants, a waiting fetch
// request is let through.
// Every output is a register.
// Optional feature: define ARB_STATS_EN to add the saturating grant counters
// i_gnt_cnt / d_gnt_cnt.
module pipeline_mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0] i_gnt_cnt,
    output logic [15:0] d_gnt_cnt,
`endif
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_D_STREAK);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_done_i;
    logic       w_done_d;
    logic [3:0] r_d_streak;

    // Next-state logic: arbitrate while IDLE, wait for m_ack while BUSY.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done_i     = 1'b0;
        w_done_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req && (!d_req || r_d_streak == LP_MAX_STREAK)) begin
                    w_grant_i    = 1'b1;
                    w_state_next = ST_BUSY_I;
                end else if (d_req) begin
                    w_grant_d    = 1'b1;
                    w_state_next = ST_BUSY_D;
                end
            end
            ST_BUSY_I: begin
                if (m_ack) begin
                    w_done_i     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                if (m_ack) begin
                    w_done_d     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Count consecutive data grants (saturating); a fetch grant clears the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                            r_d_streak <= '0;
        else if (w_grant_i)                                    r_d_streak <= '0;
        else if (w_grant_d && r_d_streak != LP_MAX_STREAK)     r_d_streak <= r_d_streak + 4'd1;
    end

    // Registered outputs: grant/complete pulses, latched memory request, read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            arb_busy <= 1'b0;
        end else begin
            i_gnt    <= w_grant_i;
            d_gnt    <= w_grant_d;
            i_rvalid <= w_done_i;
            d_rvalid <= w_done_d;
            arb_busy <= (w_state_next != ST_IDLE);
            if (w_grant_i) begin
                // The fetch port only ever reads.
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= i_addr;
                m_wdata <= '0;
            end else if (w_grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (w_done_i || w_done_d) begin
                m_req   <= 1'b0;
                m_we    <= 1'b0;
            end
            if (w_done_i)           i_rdata <= m_rdata;
            if (w_done_d && !m_we)  d_rdata <= m_rdata;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating per-port grant counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_gnt_cnt <= '0;
            d_gnt_cnt <= '0;
        end else begin
            if (w_grant_i && i_gnt_cnt != 16'hFFFF) i_gnt_cnt <= i_gnt_cnt + 16'd1;
            if (w_grant_d && d_gnt_cnt != 16'hFFFF) d_gnt_cnt <= d_gnt_cnt + 16'd1;
        end
    end
`endif

endmodule
